// File: rtl/vga_fb_arbiter_if.sv
// Host access bus of the frame-buffer arbiter: request/grant plus read return.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_rvalid
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_rvalid
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display fetches always win, host gets free slots.
// Define VGA_FB_ARB_STATS_EN to build the saturating host stall counter.
module vga_fb_arbiter #(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [DATA_W-1:0] pixel_data,
    vga_fb_arbiter_if.slave   host,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);
    typedef enum logic [1:0] {IDLE, DISP, HOST} state_e;

    localparam logic [ADDR_W:0]   FB_WORDS = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_W   = ADDR_W'(H_ACTIVE);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                host_ack_q, host_ack_d;
    logic [DATA_W-1:0]   pixel_q, host_rdata_q;
    logic                host_rvalid_q;
    // Bit 1 of each in-flight pipe lines up with the cycle mem_rdata returns.
    logic [1:0]          pix_vld_q, rd_vld_q, rd_oob_q;
    logic                pix_vis_q;
    logic                disp_slot, host_in_range;
    logic [ADDR_W-1:0]   disp_addr;

    assign disp_slot     = pix_en && blank;
    assign host_in_range = {1'b0, host.host_addr} < FB_WORDS;
    assign disp_addr     = ADDR_W'(DrawY) * LINE_W + ADDR_W'(DrawX);

    always_comb begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        host_ack_d  = 1'b0;
        if (disp_slot) begin
            state_d    = DISP;
            mem_addr_d = disp_addr;
        end else if (host.host_req && !host_ack_q) begin
            // Out-of-range writes are granted but never reach the RAM.
            state_d     = HOST;
            mem_addr_d  = host.host_addr;
            mem_we_d    = host.host_we && host_in_range;
            mem_wdata_d = host.host_wdata;
            host_ack_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            host_ack_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            pixel_q       <= '0;
            pix_vld_q     <= '0;
            pix_vis_q     <= 1'b0;
            rd_vld_q      <= '0;
            rd_oob_q      <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            host_ack_q    <= host_ack_d;
            pix_vld_q     <= {pix_vld_q[0], pix_en};
            pix_vis_q     <= (state_q == DISP);
            rd_vld_q      <= {rd_vld_q[0], host_ack_d && !host.host_we};
            rd_oob_q      <= {rd_oob_q[0], !host_in_range};
            host_rvalid_q <= rd_vld_q[1];
            if (rd_vld_q[1])
                host_rdata_q <= rd_oob_q[1] ? '0 : mem_rdata;
            if (pix_vld_q[1])
                pixel_q <= pix_vis_q ? mem_rdata : '0;
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            stall_q <= '0;
        else if (disp_slot && host.host_req && !host_ack_q && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign pixel_data       = pixel_q;
    assign mem_addr         = mem_addr_q;
    assign mem_we           = mem_we_q;
    assign mem_wdata        = mem_wdata_q;
    assign host.host_ack    = host_ack_q;
    assign host.host_rdata  = host_rdata_q;
    assign host.host_rvalid = host_rvalid_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed vector table, reset/priority sequences, random run vs model.
module tb_vga_fb_arbiter;
    localparam int DW = 8, HA = 640, VA = 480, AW = 19, FBW = HA * VA;
    localparam int NR = 400;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          pix_en, blank;
    logic [9:0]    DrawX, DrawY;
    logic [DW-1:0] pixel_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   stall_cnt;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();

    vga_fb_arbiter #(.DATA_W(DW), .H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .pixel_data(pixel_data), .host(hif), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #10 Clk = ~Clk;

    // Synchronous single-port RAM, read-before-write, with a preload port.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge Clk) begin
        mem_rdata <= ram[mem_addr];
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pre_val(input int a);
        if (a == 0) return 8'h11;
        if (a == 641) return 8'hA5;
        if (a == 307199) return 8'h5A;
        return 8'(a * 7 + 1);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " pixel"}, pixel_data, 0);
        chk({tag, " ack"}, hif.host_ack, 0);
        chk({tag, " rvalid"}, hif.host_rvalid, 0);
        chk({tag, " rdata"}, hif.host_rdata, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " stall"}, stall_cnt, 0);
    endtask

    typedef struct {
        logic pe, bl; int x, y; logic hreq, hwe; int haddr; logic [7:0] hwd;
        logic e_ack, e_we; int e_addr; logic e_rv; logic [7:0] e_rd, e_pix;
    } vec_t;

    task automatic run_vec(input vec_t v, input int i);
        @(negedge Clk);
        pix_en = v.pe; blank = v.bl; DrawX = 10'(v.x); DrawY = 10'(v.y);
        hif.host_req = v.hreq; hif.host_we = v.hwe;
        hif.host_addr = AW'(v.haddr); hif.host_wdata = v.hwd;
        @(negedge Clk);
        pix_en = 1'b0; hif.host_req = 1'b0;
        chk($sformatf("v%0d ack", i), hif.host_ack, v.e_ack);
        chk($sformatf("v%0d mem_addr", i), mem_addr, v.e_addr);
        chk($sformatf("v%0d mem_we", i), mem_we, v.e_we);
        @(negedge Clk);
        chk($sformatf("v%0d ack_pulse", i), hif.host_ack, 0);
        @(negedge Clk);
        chk($sformatf("v%0d rvalid", i), hif.host_rvalid, v.e_rv);
        if (v.e_rv) chk($sformatf("v%0d rdata", i), hif.host_rdata, v.e_rd);
        chk($sformatf("v%0d pixel", i), pixel_data, v.e_pix);
    endtask

    // Reference model state for the random run, indexed by negedge number.
    logic        e_ack [0:NR+9];
    logic        e_we  [0:NR+9];
    logic        e_rv  [0:NR+9];
    logic [7:0]  e_rd  [0:NR+9];
    logic [7:0]  e_pix [0:NR+9];
    logic [15:0] e_stall [0:NR+9];
    logic [7:0]  mm [int];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [9];
        int   pl [$];
        logic hreq_r, hwe_r, pe_r, bl_r, disp, grant, inr;
        int   haddr_r, xr, yr, da, sel;
        logic [7:0] hwd_r;
        logic [15:0] stall_exp;

        vt[0] = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 0, 8'h00,   1'b0, 1'b0, 641, 1'b0, 8'h00, 8'hA5};
        vt[1] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 100, 8'h3C, 1'b1, 1'b1, 100, 1'b0, 8'h00, 8'hA5};
        vt[2] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 100, 8'h00, 1'b1, 1'b0, 100, 1'b1, 8'h3C, 8'hA5};
        vt[3] = '{1'b1, 1'b0, 1, 1, 1'b1, 1'b0, 641, 8'h00, 1'b1, 1'b0, 641, 1'b1, 8'hA5, 8'h00};
        vt[4] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, FBW, 8'h00, 1'b1, 1'b0, FBW, 1'b1, 8'h00, 8'h00};
        vt[5] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, FBW, 8'hFF, 1'b1, 1'b0, FBW, 1'b0, 8'h00, 8'h00};
        vt[6] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 100, 8'h00, 1'b1, 1'b0, 100, 1'b1, 8'h3C, 8'h00};
        vt[7] = '{1'b1, 1'b1, 639, 479, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 307199, 1'b0, 8'h00, 8'h5A};
        vt[8] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0, 8'h00,   1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h11};

        pix_en = 1'b0; blank = 1'b0; DrawX = '0; DrawY = '0;
        hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
        Reset = 1'b1;

        for (int a = 0; a < 16; a++) begin pl.push_back(a); pl.push_back(640 + a); end
        pl.push_back(307199);
        foreach (pl[i]) begin
            @(negedge Clk);
            pl_en = 1'b1; pl_addr = AW'(pl[i]); pl_data = pre_val(pl[i]);
            mm[pl[i]] = pre_val(pl[i]);
        end
        @(negedge Clk);
        pl_en = 1'b0;
        chk_reset("por");
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Reset while a display fetch and a host read are both in flight.
        @(negedge Clk);
        pix_en = 1'b1; blank = 1'b1; DrawX = 10'd0; DrawY = 10'd1;
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = AW'(5);
        @(negedge Clk);
        pix_en = 1'b0;
        chk("rstseq ack_wait", hif.host_ack, 0);
        @(negedge Clk);
        chk("rstseq ack", hif.host_ack, 1);
        hif.host_req = 1'b0;
        #5 Reset = 1'b1;
        #1 chk_reset("mid");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("post rvalid1", hif.host_rvalid, 0);
        @(negedge Clk);
        chk("post rvalid2", hif.host_rvalid, 0);
        chk("post pixel", pixel_data, 0);

`ifdef VGA_FB_ARB_STATS_EN
        stall_exp = 16'd1;
`else
        stall_exp = 16'd0;
`endif
        // Display every second clock with a held host read.
        @(negedge Clk);
        pix_en = 1'b1; blank = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = AW'(641);
        @(negedge Clk);
        chk("share ack_wait", hif.host_ack, 0);
        chk("share stall", stall_cnt, stall_exp);
        pix_en = 1'b0;
        @(negedge Clk);
        chk("share ack", hif.host_ack, 1);
        hif.host_req = 1'b0;
        pix_en = 1'b1; DrawX = 10'd1;
        @(negedge Clk);
        chk("share ack_pulse", hif.host_ack, 0);
        chk("share pixel", pixel_data, 8'h11);
        pix_en = 1'b0;
        @(negedge Clk);
        chk("share rvalid", hif.host_rvalid, 1);
        chk("share rdata", hif.host_rdata, 8'hA5);
        chk("share stall_hold", stall_cnt, stall_exp);

        // Random traffic against the model.
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i <= NR + 9; i++) begin
            e_ack[i] = 0; e_we[i] = 0; e_rv[i] = 0; e_rd[i] = 0; e_pix[i] = 0; e_stall[i] = 0;
        end
        hreq_r = 0; hwe_r = 0; haddr_r = 0; hwd_r = 0;
        for (int t = 0; t < NR + 6; t++) begin
            @(negedge Clk);
            chk("rnd ack", hif.host_ack, e_ack[t]);
            chk("rnd mem_we", mem_we, e_we[t]);
            chk("rnd rvalid", hif.host_rvalid, e_rv[t]);
            if (e_rv[t]) chk("rnd rdata", hif.host_rdata, e_rd[t]);
            chk("rnd pixel", pixel_data, e_pix[t]);
            chk("rnd stall", stall_cnt, e_stall[t]);

            if (hreq_r && e_ack[t]) hreq_r = 0;
            if (t < NR && !hreq_r && $urandom_range(0, 2) == 0) begin
                hreq_r = 1; hwe_r = 1'($urandom_range(0, 1)); hwd_r = 8'($urandom);
                sel = $urandom_range(0, 9);
                haddr_r = (sel < 6) ? $urandom_range(0, 15) :
                          (sel < 9) ? 640 + $urandom_range(0, 15) : FBW + $urandom_range(0, 20);
            end
            pe_r = (t < NR) && ($urandom_range(0, 1) == 1);
            bl_r = ($urandom_range(0, 3) != 0);
            xr = $urandom_range(0, 15); yr = $urandom_range(0, 1);
            pix_en = pe_r; blank = bl_r; DrawX = 10'(xr); DrawY = 10'(yr);
            hif.host_req = hreq_r; hif.host_we = hwe_r;
            hif.host_addr = AW'(haddr_r); hif.host_wdata = hwd_r;

            disp  = pe_r && bl_r;
            grant = !disp && hreq_r && !e_ack[t];
            inr   = haddr_r < FBW;
            da    = yr * HA + xr;
            e_ack[t+1] = grant;
            e_we[t+1]  = grant && hwe_r && inr;
`ifdef VGA_FB_ARB_STATS_EN
            e_stall[t+1] = e_stall[t] + 16'((disp && hreq_r && !e_ack[t] && e_stall[t] != 16'hFFFF) ? 1 : 0);
`else
            e_stall[t+1] = 16'd0;
`endif
            e_rv[t+3] = grant && !hwe_r;
            e_rd[t+3] = (inr && mm.exists(haddr_r)) ? mm[haddr_r] : 8'h00;
            e_pix[t+3] = disp ? mm[da] : (pe_r ? 8'h00 : e_pix[t+2]);
            if (grant && hwe_r && inr) mm[haddr_r] = hwd_r;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: pixel/word width.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter V_ACTIVE, default 480: visible lines.
REQ-004 Parameter ADDR_W, default 19: frame buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
REQ-005 Clk  in  1  system clock, 50 MHz; all logic on posedge Clk.
REQ-006 Reset  in  1  asynchronous, active-high.
REQ-007 pix_en  in  1  one-Clk strobe per pixel, coincident with DrawX/DrawY valid.
REQ-008 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-009 blank  in  1  1 = visible region, 0 = blanking.
REQ-010 pixel_data  out  DATA_W  registered pixel value for the display DAC.
REQ-011 host_req, host_we  in  1 each  host access request and write select.
REQ-012 host_addr  in  ADDR_W; host_wdata  in  DATA_W.
REQ-013 host_ack  out  1  one-cycle grant pulse.
REQ-014 host_rdata  out  DATA_W; host_rvalid  out  1  read-return pulse.
REQ-015 mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  DATA_W: registered single-port RAM controls.
REQ-016 mem_rdata  in  DATA_W  RAM read data, valid 1 Clk after RAM samples mem_addr.
REQ-017 stall_cnt  out  16  host stall counter (see Configuration).

Function
REQ-018 FSM states IDLE, DISP, HOST; state register and all mem_* outputs registered; one RAM access per Clk.
REQ-019 Per cycle, priority: (1) pix_en=1 and blank=1 -> next DISP, mem_addr <= DrawY*H_ACTIVE+DrawX, mem_we <= 0; (2) else host_req=1 and host_ack=0 -> next HOST, mem_addr <= host_addr, mem_we <= host_we, mem_wdata <= host_wdata, host_ack <= 1; (3) else IDLE, mem_we <= 0.
REQ-020 Display address computed at ADDR_W bits without truncation for all DrawX < H_ACTIVE, DrawY < V_ACTIVE.
REQ-021 host_ack SHALL be high for exactly one Clk per grant; host_req sampled while host_ack=1 is ignored (no double grant); host holds req/addr/we/wdata stable until ack.
REQ-022 Display read latency: pixel_data updates on the 2nd Clk edge after the edge that sampled pix_en=1 and blank=1.
REQ-023 pix_en=1 with blank=0: no RAM access, slot free for host, pixel_data <= 0 at the same 2-edge latency.
REQ-024 pixel_data holds its value between updates.
REQ-025 Host read: host_rvalid pulses one Clk and host_rdata = mem_rdata on the 2nd Clk edge after the granting edge; host write: no host_rvalid.
REQ-026 host_addr >= H_ACTIVE*V_ACTIVE: ack still granted; write dropped (mem_we=0); read returns host_rdata=0 with host_rvalid.
REQ-027 pix_en and host_req in the same cycle: display wins, host granted in the next non-display cycle; with pix_en every 2nd Clk, host wait <= 2 Clk.

Reset
REQ-028 Reset asserted: state=IDLE, pixel_data=0, host_ack=0, host_rvalid=0, host_rdata=0, mem_addr=0, mem_we=0, mem_wdata=0, stall_cnt=0, all in-flight pipeline flags cleared.
REQ-029 Reset mid-access: pending host_rvalid and pixel_data updates discarded; host reissues request after release.

Configuration
REQ-030 Macro VGA_FB_ARB_STATS_EN defined: stall_cnt increments each Clk with host_req=1, host_ack=0, and display owning the slot; saturates at 16'hFFFF.
REQ-031 Macro undefined: stall_cnt tied to 0, no counter logic synthesized.

Verification
REQ-032 Reset pulse mid-frame -> all outputs per REQ-028 immediately; pixel_data=0 two edges after release.
REQ-033 RAM preloaded addr 641=8'hA5; pix_en=1, blank=1, DrawX=1, DrawY=1 -> mem_addr=641, pixel_data=8'hA5 after 2 edges.
REQ-034 host write addr 100=8'h3C then host read addr 100, pix_en idle -> two single ack pulses, host_rvalid with host_rdata=8'h3C 2 edges after 2nd ack.
REQ-035 pix_en every 2nd Clk, visible, host_req held -> ack in the non-display Clk, wait <= 2 Clk, stall_cnt=1 with macro, 0 without.
REQ-036 pix_en=1, blank=0, host_req=1 same cycle -> immediate host grant, pixel_data=0 after 2 edges.
REQ-037 host read addr 307200 -> ack, host_rvalid, host_rdata=0; host write addr 307200 -> mem_we stays 0.
